// File: rtl/tdm_burst_fifo.sv
// tdm_burst_fifo: tags TDM product words with their channel, buffers them
// and drains fixed-length bursts over a valid/ready handshake.
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   din, din_valid      product word from the multiplier (no backpressure)
//   dout, dout_chan     head-of-FIFO word and its channel tag
//   dout_valid          burst in progress, dout/dout_chan valid
//   dout_ready          consumer accepts the beat this cycle
//   dout_last           final beat of the burst
//   level               current occupancy
//   overflow            sticky, a word was dropped on a full FIFO
module tdm_burst_fifo #(
  parameter int DATA_WIDTH   = 16,
  parameter int DEPTH        = 16,
  parameter int BURST_LEN    = 4,
  parameter int NUM_CHANNELS = 2,
  localparam int CW = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1,
  localparam int LW = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  din_valid,
  output logic [DATA_WIDTH-1:0] dout,
  output logic [CW-1:0]         dout_chan,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic                  dout_last,
  output logic [LW-1:0]         level,
  output logic                  overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int EW = CW + DATA_WIDTH;

  typedef enum logic {
    IDLE,
    BURST
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] count;
  logic [BW-1:0] beat_cnt;
  logic [CW-1:0] chan_cnt;
  logic          wr_en;
  logic          rd_en;
  logic          last_beat;

  // Full is judged on the pre-edge count; a read in
  // the same cycle does not make room.
  assign wr_en     = din_valid && (count != LW'(DEPTH));
  assign rd_en     = dout_valid && dout_ready;
  assign last_beat = (beat_cnt == BW'(BURST_LEN - 1));

  assign {dout_chan, dout} = mem[rd_ptr];
  assign level = count;

  always_comb begin
    state_nxt  = state;
    dout_valid = 1'b0;
    dout_last  = 1'b0;
    unique case (state)
      IDLE: begin
        if (count >= LW'(BURST_LEN))
          state_nxt = BURST;
      end
      BURST: begin
        dout_valid = 1'b1;
        dout_last  = last_beat;
        if (dout_ready && last_beat)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      beat_cnt <= '0;
      chan_cnt <= '0;
      overflow <= 1'b0;
    end else begin
      state <= state_nxt;
      count <= count + LW'(wr_en) - LW'(rd_en);
      if (wr_en)
        wr_ptr <= wr_ptr + AW'(1);
      if (rd_en)
        rd_ptr <= rd_ptr + AW'(1);
      if (state == IDLE)
        beat_cnt <= '0;
      else if (rd_en)
        beat_cnt <= beat_cnt + BW'(1);
      // Tag advances even on a drop to stay
      // aligned with the upstream rotation.
      if (din_valid) begin
        if (chan_cnt == CW'(NUM_CHANNELS - 1))
          chan_cnt <= '0;
        else
          chan_cnt <= chan_cnt + CW'(1);
      end
      if (din_valid && !wr_en)
        overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_ptr] <= {chan_cnt, din};
  end

endmodule

// File: tb/tb_tdm_burst_fifo.sv
// tb_tdm_burst_fifo: directed and random stimulus for tdm_burst_fifo,
// scoreboard of tagged words, reference model of occupancy and flags.
module tb_tdm_burst_fifo;

  localparam int DW = 16;
  localparam int DEPTH = 16;
  localparam int BL = 4;
  localparam int NCH = 2;
  localparam int CW = 1;
  localparam int LW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] din;
  logic          din_valid;
  logic [DW-1:0] dout;
  logic [CW-1:0] dout_chan;
  logic          dout_valid;
  logic          dout_ready;
  logic          dout_last;
  logic [LW-1:0] level;
  logic          overflow;

  int total = 0;
  int bad = 0;

  tdm_burst_fifo #(
    .DATA_WIDTH(DW),
    .DEPTH(DEPTH),
    .BURST_LEN(BL),
    .NUM_CHANNELS(NCH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .din(din),
    .din_valid(din_valid),
    .dout(dout),
    .dout_chan(dout_chan),
    .dout_valid(dout_valid),
    .dout_ready(dout_ready),
    .dout_last(dout_last),
    .level(level),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // scoreboard of {chan, data} in expected read order
  logic [CW+DW-1:0] expq[$];

  // reference model: occupancy, tag rotation, sticky overflow
  int   occ;
  int   m_chan;
  logic m_ovf;
  logic prev_idle_full;

  always @(negedge clk) begin
    if (rst) begin
      expq.delete();
      occ = 0;
      m_chan = 0;
      m_ovf = 1'b0;
      prev_idle_full = 1'b0;
    end else begin
      logic wr_ok;
      check("level", 32'(level), 32'(occ));
      check("overflow", 32'(overflow), 32'(m_ovf));
      if (prev_idle_full)
        check("burst_start", 32'(dout_valid), 32'd1);
      prev_idle_full = !dout_valid && (occ >= BL);
      wr_ok = din_valid && (occ < DEPTH);
      if (wr_ok)
        expq.push_back({CW'(m_chan), din});
      if (din_valid && !wr_ok)
        m_ovf = 1'b1;
      if (din_valid)
        m_chan = (m_chan + 1) % NCH;
      occ = occ + int'(wr_ok) - int'(dout_valid && dout_ready);
    end
  end

  // monitor: pops and compares every accepted beat
  int            beats;
  logic          prev_stall;
  logic          prev_last_acc;
  logic [DW-1:0] hold_d;
  logic [CW-1:0] hold_c;
  logic          hold_l;

  always @(negedge clk) begin
    if (rst) begin
      beats = 0;
      prev_stall = 1'b0;
      prev_last_acc = 1'b0;
    end else begin
      logic [CW+DW-1:0] e;
      if (prev_last_acc)
        check("idle_gap", 32'(dout_valid), 32'd0);
      if (prev_stall) begin
        check("hold_valid", 32'(dout_valid), 32'd1);
        check("hold_data", 32'(dout), 32'(hold_d));
        check("hold_chan", 32'(dout_chan), 32'(hold_c));
        check("hold_last", 32'(dout_last), 32'(hold_l));
      end
      if (dout_valid)
        check("last", 32'(dout_last),
              32'((beats % BL) == BL - 1));
      prev_stall = dout_valid && !dout_ready;
      hold_d = dout;
      hold_c = dout_chan;
      hold_l = dout_last;
      prev_last_acc = 1'b0;
      if (dout_valid && dout_ready) begin
        if (expq.size() == 0) begin
          check("underflow", 32'd1, 32'd0);
        end else begin
          e = expq.pop_front();
          check("data", 32'(dout), 32'(e[DW-1:0]));
          check("chan", 32'(dout_chan), 32'(e[CW+DW-1:DW]));
        end
        prev_last_acc = ((beats % BL) == BL - 1);
        beats++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_words(logic [DW-1:0] base, int n);
    for (int i = 0; i < n; i++) begin
      tick();
      din_valid = 1'b1;
      din = base + DW'(i);
    end
    tick();
    din_valid = 1'b0;
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    while (n < 60) begin
      @(negedge clk);
      if (dout_valid)
        break;
      n++;
    end
    if (n >= 60)
      check("wait_valid_timeout", 32'd1, 32'd0);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (n < 400) begin
      @(negedge clk);
      if (!dout_valid && level < LW'(BL))
        break;
      n++;
    end
    if (n >= 400)
      check("drain_timeout", 32'd1, 32'd0);
    tick();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    din = '0;
    din_valid = 1'b0;
    dout_ready = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    check("rst_valid", 32'(dout_valid), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);

    // basic burst, valid rises two cycles after the 4th write
    write_words(16'h0010, 4);
    @(negedge clk);
    check("lat_k", 32'(dout_valid), 32'd0);
    @(negedge clk);
    check("lat_k1", 32'(dout_valid), 32'd1);
    check("first_beat", 32'(dout), 32'h0010);
    wait_drain();

    // stall on beat 2 for three cycles
    write_words(16'h0010, 4);
    wait_valid();
    tick();
    tick();
    dout_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_data", 32'(dout), 32'h0012);
      check("stall_chan", 32'(dout_chan), 32'd0);
    end
    tick();
    dout_ready = 1'b1;
    wait_drain();

    // partial fill never starts a burst
    write_words(16'h0030, 3);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("partial_idle", 32'(dout_valid), 32'd0);
    end
    write_words(16'h0033, 1);
    @(negedge clk);
    check("partial_k", 32'(dout_valid), 32'd0);
    @(negedge clk);
    check("partial_k1", 32'(dout_valid), 32'd1);
    wait_drain();

    // fill to full with one dropped word
    dout_ready = 1'b0;
    write_words(16'h0000, 17);
    @(negedge clk);
    check("full_level", 32'(level), 32'd16);
    check("full_ovf", 32'(overflow), 32'd1);
    tick();
    dout_ready = 1'b1;
    tick();
    dout_ready = 1'b0;
    din_valid = 1'b1;
    din = 16'h0020;
    tick();
    din_valid = 1'b0;
    dout_ready = 1'b1;
    wait_drain();

    // reset mid-burst
    write_words(16'h0040, 4);
    wait_valid();
    tick();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_valid", 32'(dout_valid), 32'd0);
    check("mid_rst_level", 32'(level), 32'd0);
    check("mid_rst_ovf", 32'(overflow), 32'd0);
    write_words(16'h0050, 4);
    wait_valid();
    check("post_rst_data", 32'(dout), 32'h0050);
    check("post_rst_chan", 32'(dout_chan), 32'd0);
    wait_drain();

    // random traffic
    for (int i = 0; i < 800; i++) begin
      tick();
      din_valid = ($urandom_range(0, 3) != 0);
      din = DW'($urandom);
      dout_ready = ($urandom_range(0, 2) != 0);
    end
    tick();
    din_valid = 1'b0;
    dout_ready = 1'b1;
    wait_drain();
    repeat (2) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
